// File: rtl/vigenere_stream_ctrl_if.sv
// Handshake and status bundle for vigenere_stream_ctrl.
//   key_start/key_wr/key_char/key_end : key load control
//   decrypt                           : direction for each accepted char
//   in_valid/in_ready/in_char         : input character stream
//   out_valid/out_ready/out_char      : output character stream
//   key_len/key_err/state_o           : status
// The "slave" modport is the controller; "master" is whoever drives it.
interface vigenere_stream_ctrl_if;
  logic       key_start;
  logic       key_wr;
  logic [7:0] key_char;
  logic       key_end;
  logic       decrypt;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_char;
  logic [3:0] key_len;
  logic       key_err;
  logic [1:0] state_o;

  modport master (
    output key_start, key_wr, key_char, key_end, decrypt, in_valid, in_char, out_ready,
    input  in_ready, out_valid, out_char, key_len, key_err, state_o
  );
  modport slave (
    input  key_start, key_wr, key_char, key_end, decrypt, in_valid, in_char, out_ready,
    output in_ready, out_valid, out_char, key_len, key_err, state_o
  );
endinterface

// File: rtl/vigenere_stream_ctrl.sv
// Streaming Vigenere cipher controller.
// A key of lowercase letters is loaded (key_start, key_wr..., key_end), then
// ASCII characters are encrypted/decrypted one per cycle with a registered
// output stage (latency 1). Non-letters come out as a space and do not
// consume a key position.
// Ports: clk, reset (async, active high), bus (slave modport, see the interface).
module vigenere_stream_ctrl #(
  parameter int KEY_MAX = 8
) (
  input logic                   clk,
  input logic                   reset,
  vigenere_stream_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2} state_t;

  localparam logic [3:0] KMAX = 4'(KEY_MAX);

  state_t     state, state_nxt;
  logic [3:0] key_len, idx;
  logic       key_err, out_valid;
  logic [7:0] out_char;
  // 16 entries so the 4-bit index never overruns, whatever KEY_MAX is
  logic [4:0] key_mem [16];

  logic       key_is_lower, wr_ok, wr_err, end_ok, end_err, accept, in_letter;
  logic [3:0] len_upd, idx_nxt;
  logic [5:0] p, k, enc_sum, enc, dec, c;
  logic [7:0] next_char;

  always_comb begin
    state_nxt    = state;
    key_is_lower = (bus.key_char >= 8'h61) && (bus.key_char <= 8'h7a);
    // key_start pre-empts any key write/commit in the same cycle
    wr_ok   = !bus.key_start && bus.key_wr && (state == LOAD) && key_is_lower && (key_len < KMAX);
    wr_err  = !bus.key_start && bus.key_wr && (state == LOAD) && !(key_is_lower && (key_len < KMAX));
    // a commit in the same cycle as a write sees the post-write length
    len_upd = key_len + {3'd0, wr_ok};
    end_ok  = !bus.key_start && bus.key_end && (state == LOAD) && (len_upd != 4'd0);
    end_err = !bus.key_start && bus.key_end && (state == LOAD) && (len_upd == 4'd0);

    if (bus.key_start)  state_nxt = LOAD;
    else if (end_ok)    state_nxt = RUN;

    bus.state_o   = state;
    bus.in_ready  = (state == RUN) && (!out_valid || bus.out_ready);
    bus.out_valid = out_valid;
    bus.out_char  = out_char;
    bus.key_len   = key_len;
    bus.key_err   = key_err;
    accept        = bus.in_valid && bus.in_ready && !bus.key_start;

    // low 6 bits of 'a'..'z' are 33..58, so subtracting 33 gives 0..25
    in_letter = (bus.in_char >= 8'h61) && (bus.in_char <= 8'h7a);
    p         = bus.in_char[5:0] - 6'd33;
    k         = {1'b0, key_mem[idx]};
    enc_sum   = p + k;
    enc       = (enc_sum >= 6'd26) ? enc_sum - 6'd26 : enc_sum;
    dec       = (p >= k) ? p - k : p + 6'd26 - k;
    c         = bus.decrypt ? dec : enc;
    next_char = in_letter ? ({2'b00, c} + 8'd97) : 8'd32;
    idx_nxt   = (idx == key_len - 4'd1) ? 4'd0 : idx + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_len   <= '0;
      idx       <= '0;
      key_err   <= 1'b0;
      out_valid <= 1'b0;
      out_char  <= 8'd32;
    end else if (bus.key_start) begin
      key_len   <= '0;
      idx       <= '0;
      key_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (wr_ok)            key_len <= len_upd;
      if (wr_err || end_err) key_err <= 1'b1;
      if (end_ok)           idx     <= '0;
      if (accept) begin
        out_valid <= 1'b1;
        out_char  <= next_char;
        if (in_letter) idx <= idx_nxt;
      end else if (bus.out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // key store keeps 0..25; 'a'..'z' low 5 bits are 1..26
  always_ff @(posedge clk) begin
    if (wr_ok) key_mem[key_len] <= bus.key_char[4:0] - 5'd1;
  end
endmodule

// File: tb/tb_vigenere_stream_ctrl.sv
module tb_vigenere_stream_ctrl;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vigenere_stream_ctrl_if bus ();
  vigenere_stream_ctrl #(.KEY_MAX(8)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  int  checks = 0;
  int  failures = 0;
  int  outs = 0;
  int  last_wait = 0;
  byte exp_q[$];
  byte tkey[$];
  int  tidx = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // reference cipher using plain modular arithmetic on the bench's key copy
  function automatic byte model(input byte ch, input bit dec);
    int p, kk, r;
    if (ch >= 97 && ch <= 122) begin
      p  = ch - 97;
      kk = tkey[tidx] - 97;
      r  = dec ? (p - kk + 26) % 26 : (p + kk) % 26;
      tidx = (tidx + 1) % tkey.size();
      return byte'(r + 97);
    end
    return 8'd32;
  endfunction

  // scoreboard: pop on every output handshake
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", exp_q.size(), 1);
      else begin
        chk("out_char", bus.out_char, exp_q.pop_front());
        outs++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_key(input string s);
    bus.key_start = 1'b1; tick(); bus.key_start = 1'b0;
    tkey.delete();
    for (int i = 0; i < s.len(); i++) begin
      bus.key_wr = 1'b1; bus.key_char = s[i]; tick();
      if (s[i] >= 97 && s[i] <= 122 && tkey.size() < 8) tkey.push_back(s[i]);
    end
    bus.key_wr = 1'b0;
    bus.key_end = 1'b1; tick(); bus.key_end = 1'b0;
    tidx = 0;
  endtask

  // present a char, wait (bounded) for in_ready, record expected result
  task automatic send(input byte ch, input bit dec);
    int w = 0;
    bus.in_valid = 1'b1; bus.in_char = ch; bus.decrypt = dec;
    @(negedge clk);
    while (!bus.in_ready && w < 20) begin w++; @(negedge clk); end
    if (bus.in_ready) exp_q.push_back(model(ch, dec));
    else chk("in_ready_timeout", bus.in_ready, 1);
    last_wait = w;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int w = 0;
    bus.in_valid = 1'b0;
    while (exp_q.size() != 0 && w < 20) begin w++; @(negedge clk); end
    chk("drain", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    reset = 1'b1;
    bus.key_start = 0; bus.key_wr = 0; bus.key_char = 0; bus.key_end = 0;
    bus.decrypt = 0; bus.in_valid = 0; bus.in_char = 0; bus.out_ready = 1;
    #12;
    chk("rst_state", bus.state_o, 0);
    chk("rst_key_len", bus.key_len, 0);
    chk("rst_key_err", bus.key_err, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_char", bus.out_char, 8'd32);
    chk("rst_in_ready", bus.in_ready, 0);
    @(posedge clk); #1 reset = 1'b0;

    // key "b", encrypt a,z
    load_key("b");
    chk("b_key_len", bus.key_len, 1);
    chk("b_state", bus.state_o, 2);
    chk("b_key_err", bus.key_err, 0);
    send("a", 0); send("z", 0); drain();

    // key "abc", back-to-back aaaa
    load_key("abc");
    o0 = outs;
    for (int i = 0; i < 4; i++) begin
      send("a", 0);
      chk("tput_wait", last_wait, 0);
    end
    drain();
    chk("tput_count", outs - o0, 4);

    // decrypt with key "b"
    load_key("b");
    send("b", 1); send("a", 1); drain();

    // space does not advance index
    load_key("ab");
    send(8'h61, 0); send(8'h20, 0); send(8'h61, 0); drain();

    // backpressure: key "ab", first output 'c' held for 3 cycles
    load_key("ab");
    bus.out_ready = 1'b0;
    o0 = outs;
    send("c", 0);
    bus.in_char = "d";
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_out_char", bus.out_char, 8'h63);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    send("d", 0); send("e", 1); drain();
    chk("bp_count", outs - o0, 3);

    // write and commit in the same cycle from an empty key
    bus.key_start = 1; tick(); bus.key_start = 0;
    bus.key_wr = 1; bus.key_char = "q"; bus.key_end = 1; tick();
    bus.key_wr = 0; bus.key_end = 0;
    chk("wrend_state", bus.state_o, 2);
    chk("wrend_key_len", bus.key_len, 1);
    chk("wrend_key_err", bus.key_err, 0);
    tkey.delete(); tkey.push_back("q"); tidx = 0;
    send("a", 0); drain();

    // key errors
    bus.key_start = 1; tick(); bus.key_start = 0;
    bus.key_end = 1; tick(); bus.key_end = 0;
    chk("empty_end_err", bus.key_err, 1);
    chk("empty_end_state", bus.state_o, 1);
    bus.key_start = 1; tick(); bus.key_start = 0;
    chk("start_clr_err", bus.key_err, 0);
    for (int i = 0; i < 9; i++) begin
      bus.key_wr = 1; bus.key_char = 8'(97 + i); tick();
    end
    bus.key_wr = 0;
    chk("ovf_key_len", bus.key_len, 8);
    chk("ovf_key_err", bus.key_err, 1);
    bus.key_start = 1; tick(); bus.key_start = 0;
    bus.key_wr = 1; bus.key_char = "A"; tick();
    chk("upper_key_err", bus.key_err, 1);
    chk("upper_key_len", bus.key_len, 0);
    bus.key_char = "c"; tick(); bus.key_wr = 0;
    bus.key_end = 1; tick(); bus.key_end = 0;
    chk("recover_state", bus.state_o, 2);
    tkey.delete(); tkey.push_back("c"); tidx = 0;

    // reset mid-stream with an output pending
    bus.out_ready = 1'b0;
    send("a", 0);
    bus.in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_state", bus.state_o, 0);
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_char", bus.out_char, 8'd32);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1; bus.in_char = "a";
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_in_ready", bus.in_ready, 0);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0;
    load_key("d");
    send("a", 0); send("w", 1); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/vigenere_stream_ctrl.md
VIGENERE_STREAM_CTRL -- requirements
Module: vigenere_stream_ctrl

Interface
REQ-001 Parameter: KEY_MAX, default 8, maximum key length in characters (legal range 2..15).
REQ-002 Port: clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: key_start  in  1  pulse; clears the stored key and enters key-load.
REQ-005 Port: key_wr  in  1  pulse; appends key_char to the key.
REQ-006 Port: key_char  in  8  ASCII key character.
REQ-007 Port: key_end  in  1  pulse; commits the key and enters run.
REQ-008 Port: decrypt  in  1  0 = encrypt, 1 = decrypt; sampled on each accepted input char.
REQ-009 Port: in_valid / in_ready / in_char  in / out / in  1/1/8  input ASCII stream handshake.
REQ-010 Port: out_valid / out_ready / out_char  out / in / out  1/1/8  output ASCII stream handshake.
REQ-011 Port: key_len  out  4  number of stored key chars.
REQ-012 Port: key_err  out  1  sticky key error flag.
REQ-013 Port: state_o  out  2  FSM state: 0 IDLE, 1 LOAD, 2 RUN.

Function
REQ-014 FSM transitions: IDLE -key_start-> LOAD; LOAD -key_end with key_len>0-> RUN; any state -key_start-> LOAD.
REQ-015 key_start clears key_len, key index, key_err and out_valid; it has priority over key_wr and key_end in the same cycle.
REQ-016 Key write in LOAD, key_char in 'a'..'z', key_len<KEY_MAX: store key_char-97 at position key_len; key_len+1.
REQ-017 Key write with a non-lowercase char, or with key_len==KEY_MAX: write dropped, key_err=1.
REQ-018 key_end in LOAD with key_len==0: state stays LOAD, key_err=1.
REQ-019 key_end in LOAD with key_len>0: state goes to RUN, key index=0.
REQ-020 key_wr and key_end: ignored outside LOAD; if both asserted in the same cycle, key_wr applies first, then key_end is evaluated on the updated key_len.
REQ-021 in_ready = (state==RUN) && (!out_valid || out_ready); in_ready is 0 in IDLE and LOAD.
REQ-022 Accept = in_valid && in_ready; on accept, out_char and out_valid=1 are registered next cycle (latency 1); full throughput of 1 char/cycle.
REQ-023 Letter path, in_char 'a'..'z': p=in_char-97, k=key[idx].
REQ-024 Letter arithmetic: encrypt c=p+k, subtract 26 if >=26; decrypt c=p-k, add 26 if negative; out_char=c+97; 6-bit intermediates, no other wrap.
REQ-025 Key index on a letter: advances; wraps to 0 after key_len-1.
REQ-026 Non-letter in_char: out_char=8'd32 (space); key index not advanced.
REQ-027 out_valid && !out_ready: out_char and out_valid hold stable; no new accept.
REQ-028 out_valid && out_ready with no accept: out_valid clears next cycle.

Reset
REQ-029 On reset assertion, immediately and regardless of clk: state=IDLE, key_len=0, key index=0, key_err=0, out_valid=0, out_char=8'd32.
REQ-030 Reset: in_ready=0; stored key contents are don't-care.
REQ-031 Reset mid-stream: any pending output is discarded; a new key must be loaded before data is accepted.

Verification
REQ-032 Load key "b", encrypt "a","z" -> out "b","a"; key_len=1.
REQ-033 Load key "abc", encrypt "aaaa" with in_valid and out_ready held high -> out "abca" on 4 consecutive cycles (index wrap, full throughput).
REQ-034 Load key "b", decrypt "b","a" -> out "a","z".
REQ-035 Load key "ab", encrypt 0x61,0x20,0x61 -> out 0x61,0x20,0x62 (space does not advance the index).
REQ-036 Backpressure, out_ready=0 for 3 cycles after the first output: in_ready=0, out_char stable; after release the stream resumes with no loss or duplication.
REQ-037 Key errors:
- key_end with no writes -> key_err=1, state_o=1.
- 9 valid writes with KEY_MAX=8 -> key_len=8, key_err=1.
- key_start -> key_err=0.
- reset asserted mid-stream -> state_o=0, out_valid=0 without a clock edge.
